spi_byte_arb: RTL and testbench

SPI_BYTE_ARB -- requirements
Module: spi_byte_arb

---
 rtl/spi_pkg.sv | 17 +
 rtl/rr_arb2.sv | 11 +
 rtl/spi_byte_arb.sv | 170 +++++++++++++++++
 tb/tb_spi_byte_arb.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and defaults for the SPI byte arbiter.
// State encodings and default timing parameters.
package spi_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_WAIT  = 3'd2,
        S_XFER  = 3'd3,
        S_HOLD  = 3'd4
    } state_t;

    localparam int unsigned CS_SETUP_DEF = 2;
    localparam int unsigned CS_HOLD_DEF  = 2;
    localparam int unsigned TMO_DEF      = 255;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin winner select.
// rr names the requester that wins a tie.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       rr,
    output logic [1:0] win
);

    assign win = (req == 2'b11) ? (rr ? 2'b10 : 2'b01) : req;

endmodule

// File: rtl/spi_byte_arb.sv
// Two-requester arbiter in front of an SPI byte engine.
// Owns chip select, frames bytes and times out idle owners.
module spi_byte_arb
    import spi_pkg::*;
#(
    parameter int unsigned CS_SETUP = CS_SETUP_DEF,
    parameter int unsigned CS_HOLD  = CS_HOLD_DEF,
    parameter int unsigned TMO      = TMO_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req,
    output logic [1:0]  gnt,
    input  logic [1:0]  req_start,
    input  logic [1:0]  req_we,
    input  logic [1:0]  req_last,
    input  logic [15:0] req_wdata,
    output logic [1:0]  req_done,
    output logic [7:0]  req_rdata,
    output logic [1:0]  err,
    output logic        spi_start,
    output logic        spi_we,
    output logic [7:0]  wdata,
    input  logic        spi_done,
    input  logic [7:0]  rdata,
    output logic        spi_cs_n
);

    localparam logic [8:0] L_SETUP = 9'(CS_SETUP);
    localparam logic [8:0] L_HOLD  = 9'(CS_HOLD);
    localparam logic [8:0] L_TMO   = 9'(TMO);

    state_t      r_state, w_state;
    logic [7:0]  r_cnt, w_cnt;
    logic [1:0]  r_gnt, w_gnt;
    logic        r_rr, w_rr;
    logic        r_cs_n, w_cs_n;
    logic        r_start, w_start;
    logic        r_we, w_we;
    logic [7:0]  r_wdata, w_wdata;
    logic        r_last, w_last;
    logic [1:0]  r_done, w_done;
    logic [7:0]  r_rdata, w_rdata;
    logic [1:0]  r_err, w_err;

    logic [1:0]  w_win;
    logic [8:0]  w_cnt_p1;
    logic        w_own;
    logic        w_own_req;
    logic        w_own_start;

    rr_arb2 u_arb (
        .req (req),
        .rr  (r_rr),
        .win (w_win)
    );

    assign w_cnt_p1    = {1'b0, r_cnt} + 9'd1;
    assign w_own       = r_gnt[1];
    assign w_own_req   = |(req & r_gnt);
    assign w_own_start = |(req_start & r_gnt);

    // Next-state and next-output logic; counter saturates by default.
    always_comb begin
        w_state = r_state;
        w_cnt   = (r_cnt == 8'hFF) ? r_cnt : r_cnt + 8'd1;
        w_gnt   = r_gnt;
        w_rr    = r_rr;
        w_cs_n  = r_cs_n;
        w_start = 1'b0;
        w_we    = r_we;
        w_wdata = r_wdata;
        w_last  = r_last;
        w_done  = 2'b00;
        w_rdata = r_rdata;
        w_err   = 2'b00;
        unique case (r_state)
            S_IDLE: begin
                if (|req) begin
                    w_gnt   = w_win;
                    w_cs_n  = 1'b0;
                    w_cnt   = 8'd0;
                    w_state = S_SETUP;
                end
            end
            S_SETUP: begin
                if (w_cnt_p1 >= L_SETUP) begin
                    w_cnt   = 8'd0;
                    w_state = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!w_own_req) begin
                    w_state = S_HOLD;
                end else if (w_own_start) begin
                    w_start = 1'b1;
                    w_we    = |(req_we & r_gnt);
                    w_last  = |(req_last & r_gnt);
                    w_wdata = w_own ? req_wdata[15:8]
                                    : req_wdata[7:0];
                    w_state = S_XFER;
                end else if (w_cnt_p1 >= L_TMO) begin
                    w_err   = r_gnt;
                    w_state = S_HOLD;
                end
            end
            S_XFER: begin
                if (spi_done) begin
                    w_done  = r_gnt;
                    w_rdata = rdata;
                    w_cnt   = 8'd0;
                    w_state = r_last ? S_HOLD : S_WAIT;
                end
            end
            S_HOLD: begin
                if (w_cnt_p1 >= L_HOLD) begin
                    w_state = S_IDLE;
                end
            end
            default: w_state = S_IDLE;
        endcase
        if (w_state == S_HOLD && r_state != S_HOLD) begin
            w_cnt  = 8'd0;
            w_gnt  = 2'b00;
            w_cs_n = 1'b1;
            w_rr   = ~w_own;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 8'd0;
            r_gnt   <= 2'b00;
            r_rr    <= 1'b0;
            r_cs_n  <= 1'b1;
            r_start <= 1'b0;
            r_we    <= 1'b0;
            r_wdata <= 8'd0;
            r_last  <= 1'b0;
            r_done  <= 2'b00;
            r_rdata <= 8'd0;
            r_err   <= 2'b00;
        end else begin
            r_state <= w_state;
            r_cnt   <= w_cnt;
            r_gnt   <= w_gnt;
            r_rr    <= w_rr;
            r_cs_n  <= w_cs_n;
            r_start <= w_start;
            r_we    <= w_we;
            r_wdata <= w_wdata;
            r_last  <= w_last;
            r_done  <= w_done;
            r_rdata <= w_rdata;
            r_err   <= w_err;
        end
    end

    assign gnt       = r_gnt;
    assign spi_cs_n  = r_cs_n;
    assign spi_start = r_start;
    assign spi_we    = r_we;
    assign wdata     = r_wdata;
    assign req_done  = r_done;
    assign req_rdata = r_rdata;
    assign err       = r_err;

endmodule

// File: tb/tb_spi_byte_arb.sv
// Directed bench for spi_byte_arb.
// The bench plays both requesters and the SPI byte engine.
module tb_spi_byte_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req;
    logic [1:0]  gnt;
    logic [1:0]  req_start;
    logic [1:0]  req_we;
    logic [1:0]  req_last;
    logic [15:0] req_wdata;
    logic [1:0]  req_done;
    logic [7:0]  req_rdata;
    logic [1:0]  err;
    logic        spi_start;
    logic        spi_we;
    logic [7:0]  wdata;
    logic        spi_done;
    logic [7:0]  rdata;
    logic        spi_cs_n;

    int errs   = 0;
    int checks = 0;
    int n_start = 0;
    int base;

    spi_byte_arb #(
        .CS_SETUP (2),
        .CS_HOLD  (2),
        .TMO      (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .gnt       (gnt),
        .req_start (req_start),
        .req_we    (req_we),
        .req_last  (req_last),
        .req_wdata (req_wdata),
        .req_done  (req_done),
        .req_rdata (req_rdata),
        .err       (err),
        .spi_start (spi_start),
        .spi_we    (spi_we),
        .wdata     (wdata),
        .spi_done  (spi_done),
        .rdata     (rdata),
        .spi_cs_n  (spi_cs_n)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (spi_start) n_start++;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(string tag, logic [15:0] obs,
                       logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic do_byte(int idx, logic we, logic [7:0] d,
                           logic last, logic [7:0] rd,
                           string tg);
        logic [1:0] own;
        own = (idx == 1) ? 2'b10 : 2'b01;
        req_start[idx] = 1'b1;
        req_we[idx] = we;
        req_last[idx] = last;
        req_wdata[8*idx +: 8] = d;
        tick();
        req_start = 2'b00;
        chk({tg, "_start"}, 16'(spi_start), 16'd1);
        chk({tg, "_wdata"}, 16'(wdata), 16'(d));
        chk({tg, "_we"}, 16'(spi_we), 16'(we));
        chk({tg, "_csn_a"}, 16'(spi_cs_n), 16'd0);
        tick();
        chk({tg, "_start1"}, 16'(spi_start), 16'd0);
        chk({tg, "_csn_b"}, 16'(spi_cs_n), 16'd0);
        spi_done = 1'b1;
        rdata = rd;
        tick();
        spi_done = 1'b0;
        chk({tg, "_done"}, 16'(req_done), 16'(own));
        chk({tg, "_rdata"}, 16'(req_rdata), 16'(rd));
        chk({tg, "_csn_c"}, 16'(spi_cs_n), 16'(last));
    endtask

    initial begin
        rst = 1'b1;
        req = 2'b00;
        req_start = 2'b00;
        req_we = 2'b00;
        req_last = 2'b00;
        req_wdata = 16'h0000;
        spi_done = 1'b0;
        rdata = 8'h00;
        tick();
        tick();
        chk("rst_gnt", 16'(gnt), 16'd0);
        chk("rst_csn", 16'(spi_cs_n), 16'd1);
        chk("rst_start", 16'(spi_start), 16'd0);
        chk("rst_we", 16'(spi_we), 16'd0);
        chk("rst_wdata", 16'(wdata), 16'd0);
        chk("rst_done", 16'(req_done), 16'd0);
        chk("rst_rdata", 16'(req_rdata), 16'd0);
        chk("rst_err", 16'(err), 16'd0);
        rst = 1'b0;
        tick();

        // Single six-byte frame from requester 0.
        base = n_start;
        req = 2'b01;
        tick();
        chk("f1_gnt", 16'(gnt), 16'b01);
        chk("f1_csn", 16'(spi_cs_n), 16'd0);
        tick();
        tick();
        do_byte(0, 1'b1, 8'h90, 1'b0, 8'h00, "f1b1");
        do_byte(0, 1'b1, 8'h00, 1'b0, 8'h00, "f1b2");
        do_byte(0, 1'b1, 8'h00, 1'b0, 8'h00, "f1b3");
        do_byte(0, 1'b1, 8'h00, 1'b0, 8'h00, "f1b4");
        do_byte(0, 1'b0, 8'h00, 1'b0, 8'hEF, "f1b5");
        do_byte(0, 1'b0, 8'h00, 1'b1, 8'h17, "f1b6");
        req = 2'b00;
        chk("f1_gnt_end", 16'(gnt), 16'd0);
        tick();
        chk("f1_done_1cyc", 16'(req_done), 16'd0);
        chk("f1_nstart", 16'(n_start - base), 16'd6);
        tick();
        tick();

        // Contention from rr = 0 after a fresh reset.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        req = 2'b11;
        tick();
        chk("c_gnt0", 16'(gnt), 16'b01);
        tick();
        tick();
        do_byte(0, 1'b1, 8'hA5, 1'b1, 8'h00, "c0");
        req = 2'b10;
        chk("c_gnt_hold", 16'(gnt), 16'd0);
        tick();
        chk("c_csn_h1", 16'(spi_cs_n), 16'd1);
        tick();
        chk("c_csn_h2", 16'(spi_cs_n), 16'd1);
        tick();
        chk("c_gnt1", 16'(gnt), 16'b10);
        chk("c_csn_lo", 16'(spi_cs_n), 16'd0);
        tick();
        tick();
        do_byte(1, 1'b0, 8'h00, 1'b1, 8'h3C, "c1");
        req = 2'b00;
        tick();
        tick();
        tick();

        // Non-owner start and stray spi_done while 0 owns.
        req = 2'b01;
        tick();
        tick();
        tick();
        do_byte(0, 1'b1, 8'h5A, 1'b0, 8'h00, "n0");
        req_start = 2'b10;
        req_wdata[15:8] = 8'hC3;
        tick();
        req_start = 2'b00;
        chk("n_nostart", 16'(spi_start), 16'd0);
        chk("n_wdata", 16'(wdata), 16'h5A);
        spi_done = 1'b1;
        rdata = 8'h99;
        tick();
        spi_done = 1'b0;
        chk("n_stray_done", 16'(req_done), 16'd0);
        chk("n_rdata_keep", 16'(req_rdata), 16'h00);
        req = 2'b00;
        tick();
        chk("n_end_err", 16'(err), 16'd0);
        chk("n_end_csn", 16'(spi_cs_n), 16'd1);
        tick();
        tick();
        tick();

        // Timeout with TMO = 4: err on the 5th WAIT cycle.
        req = 2'b01;
        tick();
        tick();
        tick();
        for (int i = 1; i <= 4; i++) begin
            chk($sformatf("t_noerr%0d", i), 16'(err), 16'd0);
            tick();
        end
        chk("t_err", 16'(err), 16'b01);
        chk("t_gnt", 16'(gnt), 16'd0);
        req = 2'b00;
        tick();
        chk("t_err_1cyc", 16'(err), 16'd0);
        chk("t_csn", 16'(spi_cs_n), 16'd1);
        tick();
        tick();
        tick();

        // Reset in the middle of a transfer.
        req = 2'b01;
        tick();
        tick();
        tick();
        req_start = 2'b01;
        req_we = 2'b01;
        req_last = 2'b00;
        req_wdata[7:0] = 8'h42;
        tick();
        req_start = 2'b00;
        chk("r_start", 16'(spi_start), 16'd1);
        #2;
        rst = 1'b1;
        req = 2'b00;
        #1;
        chk("r_csn_async", 16'(spi_cs_n), 16'd1);
        chk("r_gnt_async", 16'(gnt), 16'd0);
        tick();
        rst = 1'b0;
        tick();
        spi_done = 1'b1;
        rdata = 8'h77;
        tick();
        spi_done = 1'b0;
        chk("r_no_done", 16'(req_done), 16'd0);
        chk("r_no_err", 16'(err), 16'd0);
        chk("r_rdata", 16'(req_rdata), 16'd0);
        tick();
        chk("r_no_done2", 16'(req_done), 16'd0);
        chk("r_csn_idle", 16'(spi_cs_n), 16'd1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
